// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared types and constants for the instruction cache
package rapid_pkg;

    typedef logic [127:0] qword_t;

    localparam int ICACHE_LINE_BYTES  = 16;
    localparam int ICACHE_OFFSET_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        HOLD,
        MISS_REQ,
        MISS_WAIT,
        FLUSH
    } icache_state_t;

    // Memory-controller side of a single-outstanding line read.
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } mem_req_t;

    typedef struct packed {
        logic   ready;
        logic   rvalid;
        qword_t rdata;
    } mem_rsp_t;

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - tag+data array, one synchronous read port and one write port
module icache_line_ram
    import rapid_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int TAG_W     = 22,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output qword_t           rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  qword_t           wr_data
);

    logic [TAG_W-1:0] tag_mem  [NUM_LINES];
    qword_t           data_mem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[rd_idx];
        end
    end

endmodule

// File: rtl/icache_dm1cycle.sv
// rtl/icache_dm1cycle.sv - direct-mapped read-only I-cache, 1-cycle hit; ICACHE_INVALIDATE_EN adds i_invalidate/FLUSH
module icache_dm1cycle
    import rapid_pkg::*;
#(
    parameter int NUM_LINES   = 64,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 128
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    input  logic                   i_valid,
    input  logic                   i_rw,
`ifdef ICACHE_INVALIDATE_EN
    input  logic                   i_invalidate,
`endif
    output logic                   o_ready,
    output logic                   o_rvalid,
    output logic [DATA_LENGTH-1:0] o_rdata,
    output logic                   o_mem_valid,
    output logic [ADDR_LENGTH-1:0] o_mem_addr,
    input  logic                   i_mem_ready,
    input  logic                   i_mem_rvalid,
    input  logic [DATA_LENGTH-1:0] i_mem_rdata
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_LENGTH - ICACHE_OFFSET_BITS - IDX_W;

    icache_state_t          state, state_nx;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [NUM_LINES-1:0]   line_valid;
    qword_t                 rdata_q, ram_data;
    logic [TAG_W-1:0]       ram_tag, tag_q;
    logic [IDX_W-1:0]       idx_q, req_idx;
    logic                   hit, fill, ready_st, rd_accept, inv_now;
    mem_req_t               mem_req;
    mem_rsp_t               mem_rsp;
    logic                   unused_bits;

    assign mem_rsp     = '{ready: i_mem_ready, rvalid: i_mem_rvalid, rdata: i_mem_rdata};
    assign o_mem_valid = mem_req.valid;
    assign o_mem_addr  = mem_req.addr;
    assign unused_bits = ^{i_addr[ICACHE_OFFSET_BITS-1:0], addr_q[ICACHE_OFFSET_BITS-1:0]};

    assign req_idx = i_addr[ICACHE_OFFSET_BITS +: IDX_W];
    assign idx_q   = addr_q[ICACHE_OFFSET_BITS +: IDX_W];
    assign tag_q   = addr_q[ADDR_LENGTH-1 -: TAG_W];
    assign hit     = line_valid[idx_q] && (ram_tag == tag_q);
    assign fill    = (state == MISS_WAIT) && mem_rsp.rvalid;

`ifdef ICACHE_INVALIDATE_EN
    logic             inv_pending;
    logic [IDX_W-1:0] flush_idx;
    logic             flush_done;

    assign inv_now    = i_invalidate || inv_pending;
    assign flush_done = (flush_idx == IDX_W'(NUM_LINES - 1));
`else
    assign inv_now = 1'b0;
`endif

    always_comb begin
        ready_st = 1'b0;
        case (state)
            IDLE, HOLD: ready_st = 1'b1;
            LOOKUP:     ready_st = hit;
            default:    ready_st = 1'b0;
        endcase
    end

    // Writes are accepted but never start a lookup.
    assign o_ready   = !i_reset && ready_st && !inv_now;
    assign rd_accept = o_ready && i_valid && !i_rw;
    assign o_rvalid  = !i_reset && ((state == HOLD) || ((state == LOOKUP) && hit));
    assign o_rdata   = ((state == LOOKUP) && hit) ? ram_data : rdata_q;

    always_comb begin
        mem_req.valid = !i_reset && (state == MISS_REQ);
        mem_req.addr  = {addr_q[ADDR_LENGTH-1:ICACHE_OFFSET_BITS], {ICACHE_OFFSET_BITS{1'b0}}};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, HOLD: begin
                if (rd_accept) state_nx = LOOKUP;
`ifdef ICACHE_INVALIDATE_EN
                if (inv_now) state_nx = FLUSH;
`endif
            end
            LOOKUP: begin
                if (!hit)          state_nx = MISS_REQ;
                else if (rd_accept) state_nx = LOOKUP;
                else               state_nx = HOLD;
`ifdef ICACHE_INVALIDATE_EN
                if (hit && inv_now) state_nx = FLUSH;
`endif
            end
            MISS_REQ:  if (mem_rsp.ready)  state_nx = MISS_WAIT;
            MISS_WAIT: if (mem_rsp.rvalid) state_nx = HOLD;
`ifdef ICACHE_INVALIDATE_EN
            FLUSH:     if (flush_done)     state_nx = IDLE;
`endif
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (rd_accept) addr_q <= i_addr;
            // Capture the hit line so HOLD keeps presenting it; fill data is bypassed the same way.
            if ((state == LOOKUP) && hit) rdata_q <= ram_data;
            if (fill)                     rdata_q <= mem_rsp.rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            line_valid <= '0;
        end else begin
            if (fill) line_valid[idx_q] <= 1'b1;
`ifdef ICACHE_INVALIDATE_EN
            if (state == FLUSH) line_valid[flush_idx] <= 1'b0;
`endif
        end
    end

`ifdef ICACHE_INVALIDATE_EN
    // An invalidate seen while a miss is in flight is remembered and serviced after the fill is delivered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            inv_pending <= 1'b0;
            flush_idx   <= '0;
        end else begin
            if ((state_nx == FLUSH) && (state != FLUSH))
                inv_pending <= 1'b0;
            else if (i_invalidate && ((state == MISS_REQ) || (state == MISS_WAIT) ||
                                      ((state == LOOKUP) && !hit)))
                inv_pending <= 1'b1;
            if (state == FLUSH) flush_idx <= flush_idx + 1'b1;
            else                flush_idx <= '0;
        end
    end
`endif

    icache_line_ram #(
        .NUM_LINES (NUM_LINES),
        .TAG_W     (TAG_W)
    ) u_line_ram (
        .clk     (i_clk),
        .rd_en   (rd_accept),
        .rd_idx  (req_idx),
        .rd_tag  (ram_tag),
        .rd_data (ram_data),
        .wr_en   (fill),
        .wr_idx  (idx_q),
        .wr_tag  (tag_q),
        .wr_data (mem_rsp.rdata)
    );

endmodule

// File: doc/icache_dm1cycle.md
Name: icache_dm1cycle

Overview:
- Read-only, direct-mapped instruction cache; the responder (secondary) side of the 128-bit cache request interface driven by the instruction fetch unit.
- Returns one 16-byte block (4 instructions) per accepted request, with 1-cycle hit latency.
- On a miss, fetches the whole line from the memory controller over a single-outstanding read handshake.
- Top level packs/unpacks the memory-side ports into the controller's request/response structs.

Parameters:
- NUM_LINES, 64, number of 16-byte lines; power of two, >= 2.
- ADDR_LENGTH, 32, address width.
- DATA_LENGTH, 128, line/read-bus width; fixed at 128.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_addr  in  32  request byte address; bits [3:0] ignored
- i_valid  in  1  request strobe; accepted on a cycle with i_valid && o_ready
- i_rw  in  1  must be 0; write requests are ignored
- o_ready  out  1  cache can accept a request this cycle
- o_rvalid  out  1  o_rdata holds the line of the last accepted address
- o_rdata  out  128  line data; word k = o_rdata[32*k +: 32]
- o_mem_valid  out  1  line-read request to the memory controller
- o_mem_addr  out  32  line-aligned address, low 4 bits 0
- i_mem_ready  in  1  controller accepts o_mem_valid this cycle
- i_mem_rvalid  in  1  one-cycle pulse with the fill data
- i_mem_rdata  in  128  fill line

Behaviour:
- Address split:
  - index = addr[4 +: log2(NUM_LINES)]
  - tag = addr[31 : 4+log2(NUM_LINES)]
  - per-line valid bit, held in flops.
- Reset values: o_ready=0, o_rvalid=0, o_rdata=0, o_mem_valid=0, o_mem_addr=0. All valid bits cleared. State=IDLE.
- IDLE (first cycle after reset)
  - o_ready=1, o_rvalid=0.
  - On accept: latch addr, go LOOKUP.
- LOOKUP (cycle N+1 after accept at edge N):
  - Hit: o_rvalid=1, o_rdata=stored line, o_ready=1. A new accept in this cycle stays in LOOKUP (back-to-back hits, 1 block/cycle). Otherwise go HOLD.
  - Miss: o_rvalid=0, o_ready=0, go MISS_REQ.
- HOLD:
  - o_rvalid=1; o_rdata stable; o_ready=1.
  - Accept → LOOKUP.
- MISS_REQ:
  - o_mem_valid=1; o_mem_addr={latched[31:4],4'b0}.
  - Held until i_mem_ready; then go MISS_WAIT.
- MISS_WAIT:
  - o_mem_valid=0.
  - On i_mem_rvalid: write data, tag and valid=1 to the line; go HOLD.
  - Fill data is bypassed, so o_rvalid=1 with i_mem_rdata in the next cycle (miss latency = 2 + memory latency).
- o_ready=0 and o_rvalid=0 throughout MISS_REQ/MISS_WAIT.
- o_rvalid always refers to the last accepted address. In the accept cycle it still reflects the previous address. The fetch unit relies on this.
- Write requests: i_valid with i_rw=1 is accepted as a no-op. State, o_rvalid and o_rdata are unchanged.
- Same-index conflict: a fill overwrites the line unconditionally (direct-mapped).
- Reset mid-miss: returns to IDLE and clears valid bits. The memory controller shares the same reset, so no stale i_mem_rvalid arrives.
- i_mem_rvalid outside MISS_WAIT is ignored.

Optional Feature:
- Macro: ICACHE_INVALIDATE_EN.
- Defined:
  - Adds port i_invalidate (in, 1), used for fence.i.
  - Sampled in IDLE/HOLD/LOOKUP. Has priority over a same-cycle i_valid, which is not accepted.
  - Enters FLUSH, clearing one valid bit per cycle for NUM_LINES cycles, with o_ready=0 and o_rvalid=0. Then returns to IDLE.
  - During a miss, the request is latched and acted on after the fill completes.
- Undefined: no port, no FLUSH state; valid bits are cleared only by reset.

Decomposition:
- rapid_pkg gets:
  - typedef qword_t (logic [127:0])
  - ICACHE_LINE_BYTES=16
  - ICACHE_OFFSET_BITS=4
  - state enum icache_state_t {IDLE, LOOKUP, HOLD, MISS_REQ, MISS_WAIT, FLUSH}.
- Sub-module icache_line_ram:
  - Tag+data array, NUM_LINES x (tag+128), synchronous read and write, one port each.
  - Valid bits stay in the parent so they can be cleared by reset/flush.

Test Plan:
- Cold miss: reset, request 0x0000_1000 → o_mem_valid with o_mem_addr=0x0000_1000. Memory returns 0xDDDD_CCCC_BBBB_AAAA... after 3 cycles → o_rvalid=1, o_rdata matches. o_ready=0 during the miss.
- Hit after fill: re-request 0x0000_1008 → o_rvalid=1 next cycle, same line, no o_mem_valid.
- Back-to-back hits: prefill 0x1000 and 0x1010, then request both on consecutive cycles → o_rvalid=1 for 2 consecutive cycles with lines in order.
- Conflict eviction (NUM_LINES=64): fill 0x1000, then request 0x1400 (same index) → miss; re-request 0x1000 → miss again.
- Handshake stall: hold i_mem_ready=0 for 5 cycles → o_mem_valid and o_mem_addr stable, o_ready=0. Assert reset mid-wait → next cycle o_mem_valid=0, state IDLE, previously filled line now misses.
- With ICACHE_INVALIDATE_EN: fill 0x1000, pulse i_invalidate → o_ready=0 for 64 cycles; request 0x1000 → miss.
